// File: rtl/pw_trigger_seq_if.sv
// pw_trigger_seq_if: control, configuration and status bundle for the
// trigger sequencer. The master side drives the I_* fields and observes
// the O_* fields. The slave side (the sequencer) does the opposite.
interface pw_trigger_seq_if #(
  parameter int pNUM_PULSES   = 8,
  parameter int pDELAY_WIDTH  = 20,
  parameter int pWIDTH_WIDTH  = 17,
  parameter int pNUM_WIDTH    = 4,
  parameter int pREPEAT_WIDTH = 8
);
  logic                                  I_match;
  logic                                  I_arm;
  logic                                  I_rearm;
  logic                                  I_abort;
  logic [pNUM_PULSES*pDELAY_WIDTH-1:0]   I_trigger_delay;
  logic [pNUM_PULSES*pWIDTH_WIDTH-1:0]   I_trigger_width;
  logic [pNUM_WIDTH-1:0]                 I_num_triggers;
  logic [pREPEAT_WIDTH-1:0]              I_repeat;
  logic                                  O_trigger;
  logic                                  O_armed;
  logic                                  O_busy;
  logic                                  O_done;
  logic                                  O_overrun;

  modport master (
    output I_match, I_arm, I_rearm, I_abort,
    output I_trigger_delay, I_trigger_width, I_num_triggers, I_repeat,
    input  O_trigger, O_armed, O_busy, O_done, O_overrun
  );

  modport slave (
    input  I_match, I_arm, I_rearm, I_abort,
    input  I_trigger_delay, I_trigger_width, I_num_triggers, I_repeat,
    output O_trigger, O_armed, O_busy, O_done, O_overrun
  );
endinterface

// File: rtl/pw_trigger_seq.sv
// pw_trigger_seq: programmable multi-pulse trigger sequencer.
// Once armed, a match pulse starts the sequence. The sequencer snapshots the
// per-pulse delay and width tables and emits up to pNUM_PULSES pulses on
// O_trigger. All outputs are registered.
// Optional feature: define TRIG_SEQ_REPEAT_EN to replay the whole sequence
// I_repeat extra times before O_done is asserted. Delay 0 is the gap between
// repetitions.
module pw_trigger_seq #(
  parameter int pNUM_PULSES   = 8,
  parameter int pDELAY_WIDTH  = 20,
  parameter int pWIDTH_WIDTH  = 17,
  parameter int pNUM_WIDTH    = 4,
  parameter int pREPEAT_WIDTH = 8
) (
  input logic             trigger_clk,
  input logic             reset_n,
  pw_trigger_seq_if.slave bus
);

  localparam int CNT_W     = (pDELAY_WIDTH > pWIDTH_WIDTH) ? pDELAY_WIDTH : pWIDTH_WIDTH;
  localparam int DLY_VEC_W = pNUM_PULSES * pDELAY_WIDTH;
  localparam int WID_VEC_W = pNUM_PULSES * pWIDTH_WIDTH;
  localparam logic [pNUM_WIDTH-1:0] NUM_MAX = pNUM_WIDTH'(pNUM_PULSES);
  localparam logic [pNUM_WIDTH-1:0] IDX_ONE = pNUM_WIDTH'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);

  // Reject configurations the count field or repeat field cannot represent.
  if (pNUM_PULSES < 1 || pNUM_PULSES >= (1 << pNUM_WIDTH) || pREPEAT_WIDTH < 1) begin : g_bad_cfg
    $error("pw_trigger_seq: inconsistent parameter set");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    WAIT_ON  = 2'd2,
    WAIT_OFF = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [pNUM_WIDTH-1:0]  idx_q, idx_d;
  logic [pNUM_WIDTH-1:0]  num_q, num_d;
  logic [DLY_VEC_W-1:0]   delay_q, delay_d;
  logic [WID_VEC_W-1:0]   width_q, width_d;
  logic                   trigger_q, trigger_d;
  logic                   armed_q, armed_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   overrun_q, overrun_d;
`ifdef TRIG_SEQ_REPEAT_EN
  logic [pREPEAT_WIDTH-1:0] rep_q, rep_d;
`endif

  logic [pNUM_WIDTH-1:0]  num_eff;
  logic [pNUM_WIDTH-1:0]  idx_next;
  logic [CNT_W-1:0]       first_delay;
  logic [CNT_W-1:0]       first_width;
  state_t                 end_state;

  function automatic logic [CNT_W-1:0] delay_at(input logic [DLY_VEC_W-1:0] vec, input int k);
    return CNT_W'(vec[k*pDELAY_WIDTH +: pDELAY_WIDTH]);
  endfunction

  function automatic logic [CNT_W-1:0] width_at(input logic [WID_VEC_W-1:0] vec, input int k);
    return CNT_W'(vec[k*pWIDTH_WIDTH +: pWIDTH_WIDTH]);
  endfunction

  // The counter holds "cycles left after this one".
  // A programmed value of 0 is treated as a one-cycle phase.
  function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : (v - CNT_ONE);
  endfunction

  // Next-state, counter, snapshot and output decisions; abort overrides everything.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    num_d       = num_q;
    delay_d     = delay_q;
    width_d     = width_q;
    trigger_d   = trigger_q;
    done_d      = 1'b0;
    overrun_d   = 1'b0;
`ifdef TRIG_SEQ_REPEAT_EN
    rep_d       = rep_q;
`endif
    num_eff     = (bus.I_num_triggers > NUM_MAX) ? NUM_MAX : bus.I_num_triggers;
    idx_next    = idx_q + IDX_ONE;
    first_delay = delay_at(bus.I_trigger_delay, 0);
    first_width = width_at(bus.I_trigger_width, 0);
    end_state   = (bus.I_rearm && bus.I_arm) ? ARMED : IDLE;

    if (bus.I_abort) begin
      state_d   = IDLE;
      trigger_d = 1'b0;
      cnt_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.I_arm) state_d = ARMED;
        end
        ARMED: begin
          if (bus.I_match) begin
            delay_d = bus.I_trigger_delay;
            width_d = bus.I_trigger_width;
            num_d   = num_eff;
            idx_d   = '0;
`ifdef TRIG_SEQ_REPEAT_EN
            rep_d   = bus.I_repeat;
`endif
            if (num_eff == '0) begin
              done_d  = 1'b1;
              state_d = end_state;
            end else if (first_delay == '0) begin
              state_d   = WAIT_OFF;
              trigger_d = 1'b1;
              cnt_d     = load_val(first_width);
            end else begin
              state_d = WAIT_ON;
              cnt_d   = load_val(first_delay);
            end
          end else if (!bus.I_arm) begin
            state_d = IDLE;
          end
        end
        WAIT_ON: begin
          overrun_d = bus.I_match;
          if (cnt_q == '0) begin
            state_d   = WAIT_OFF;
            trigger_d = 1'b1;
            cnt_d     = load_val(width_at(width_q, int'(idx_q)));
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        WAIT_OFF: begin
          overrun_d = bus.I_match;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            trigger_d = 1'b0;
            if (idx_next < num_q) begin
              idx_d   = idx_next;
              state_d = WAIT_ON;
              cnt_d   = load_val(delay_at(delay_q, int'(idx_next)));
            end
`ifdef TRIG_SEQ_REPEAT_EN
            else if (rep_q != '0) begin
              rep_d   = rep_q - pREPEAT_WIDTH'(1);
              idx_d   = '0;
              state_d = WAIT_ON;
              cnt_d   = load_val(delay_at(delay_q, 0));
            end
`endif
            else begin
              done_d  = 1'b1;
              state_d = end_state;
            end
          end
        end
        default: begin
          state_d   = IDLE;
          trigger_d = 1'b0;
        end
      endcase
    end

    armed_d = (state_d == ARMED);
    busy_d  = (state_d == WAIT_ON) || (state_d == WAIT_OFF);
  end

  // State, counters, snapshot and registered outputs with synchronous reset.
  always_ff @(posedge trigger_clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      num_q     <= '0;
      delay_q   <= '0;
      width_q   <= '0;
      trigger_q <= 1'b0;
      armed_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef TRIG_SEQ_REPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      num_q     <= num_d;
      delay_q   <= delay_d;
      width_q   <= width_d;
      trigger_q <= trigger_d;
      armed_q   <= armed_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
`ifdef TRIG_SEQ_REPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  assign bus.O_trigger = trigger_q;
  assign bus.O_armed   = armed_q;
  assign bus.O_busy    = busy_q;
  assign bus.O_done    = done_q;
  assign bus.O_overrun = overrun_q;

endmodule

// File: tb/tb_pw_trigger_seq.sv
// tb_pw_trigger_seq: directed, table-driven bench for pw_trigger_seq.
// Cycle-by-cycle vectors cover arm/disarm, single pulses, done, overrun and abort.
// Hand-written sequences cover multi-pulse timing, reset mid-pulse, clamping
// and repetition. Build with TRIG_SEQ_REPEAT_EN to exercise the repeat feature.
module tb_pw_trigger_seq;

  logic trigger_clk;
  logic reset_n;

  pw_trigger_seq_if bus ();

  pw_trigger_seq dut (
    .trigger_clk (trigger_clk),
    .reset_n     (reset_n),
    .bus         (bus)
  );

  typedef struct {
    logic       rst_n;
    logic       arm;
    logic       rearm;
    logic       match;
    logic       abort;
    logic [3:0] num;
    logic [4:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   dly[8];
  int   wid[8];
  int   expTrig[$];
  int   trTrig[$];
  int   trDone[$];
  int   trOvr[$];
  int   trArmed[$];
  int   trBusy[$];

  // Free-running 10-time-unit clock.
  initial begin
    trigger_clk = 1'b0;
    forever #5 trigger_clk = ~trigger_clk;
  end

  task automatic tick();
    @(posedge trigger_clk);
    #1;
  endtask

  function automatic int outBits();
    return int'({bus.O_trigger, bus.O_armed, bus.O_busy, bus.O_done, bus.O_overrun});
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic addVec(input logic rn, input logic a, input logic rr, input logic m,
                        input logic ab, input int n, input logic [4:0] e, input string nm);
    vec_t v;
    v.rst_n = rn; v.arm = a; v.rearm = rr; v.match = m; v.abort = ab;
    v.num = 4'(n); v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    reset_n            = v.rst_n;
    bus.I_arm          = v.arm;
    bus.I_rearm        = v.rearm;
    bus.I_match        = v.match;
    bus.I_abort        = v.abort;
    bus.I_num_triggers = v.num;
    tick();
  endtask

  task automatic clearCfg();
    for (int k = 0; k < 8; k++) begin
      dly[k] = 0;
      wid[k] = 0;
    end
  endtask

  task automatic setConfig(input int n, input int rep);
    for (int k = 0; k < 8; k++) begin
      bus.I_trigger_delay[k*20 +: 20] = 20'(dly[k]);
      bus.I_trigger_width[k*17 +: 17] = 17'(wid[k]);
    end
    bus.I_num_triggers = 4'(n);
    bus.I_repeat       = 8'(rep);
  endtask

  task automatic scrambleInputs();
    for (int k = 0; k < 8; k++) begin
      bus.I_trigger_delay[k*20 +: 20] = 20'($urandom_range(0, 40));
      bus.I_trigger_width[k*17 +: 17] = 17'($urandom_range(0, 40));
    end
    bus.I_num_triggers = 4'($urandom_range(0, 15));
    bus.I_repeat       = 8'($urandom_range(0, 5));
  endtask

  task automatic resetAndArm();
    reset_n     = 1'b0;
    bus.I_arm   = 1'b0;
    bus.I_match = 1'b0;
    bus.I_abort = 1'b0;
    tick();
    reset_n     = 1'b1;
    bus.I_arm   = 1'b1;
    bus.I_rearm = 1'b1;
    tick();
  endtask

  // Expected O_trigger trace starting the cycle after the match.
  // The first delay is exact. Every other gap and every width is at least one cycle.
  task automatic buildExp(input int n, input int reps);
    int lo;
    int hi;
    expTrig.delete();
    for (int r = 0; r <= reps; r++) begin
      for (int k = 0; k < n; k++) begin
        lo = (r == 0 && k == 0) ? dly[k] : ((dly[k] < 1) ? 1 : dly[k]);
        hi = (wid[k] < 1) ? 1 : wid[k];
        repeat (lo) expTrig.push_back(0);
        repeat (hi) expTrig.push_back(1);
      end
    end
  endtask

  // Match in the first traced cycle, with optional second match, abort and input scramble.
  task automatic runTrace(input int cycles, input int matchAt, input int abortAt, input int scrambleAt);
    trTrig.delete(); trDone.delete(); trOvr.delete(); trArmed.delete(); trBusy.delete();
    for (int i = 0; i < cycles; i++) begin
      bus.I_match = (i == 0) || (i == matchAt);
      bus.I_abort = (i == abortAt);
      if (i == scrambleAt) scrambleInputs();
      tick();
      trTrig.push_back(int'(bus.O_trigger));
      trDone.push_back(int'(bus.O_done));
      trOvr.push_back(int'(bus.O_overrun));
      trArmed.push_back(int'(bus.O_armed));
      trBusy.push_back(int'(bus.O_busy));
    end
    bus.I_match = 1'b0;
    bus.I_abort = 1'b0;
  endtask

  function automatic int countOnes(input int q[$]);
    int c = 0;
    foreach (q[j]) if (q[j] != 0) c++;
    return c;
  endfunction

  function automatic int firstOne(input int q[$]);
    foreach (q[j]) if (q[j] != 0) return j;
    return -1;
  endfunction

  function automatic int countRising(input int q[$]);
    int c = 0;
    foreach (q[j]) if (q[j] != 0 && (j == 0 || q[j-1] == 0)) c++;
    return c;
  endfunction

  task automatic checkTrace(input string name);
    int mism = 0;
    int e;
    foreach (trTrig[j]) begin
      e = (j < expTrig.size()) ? expTrig[j] : 0;
      if (trTrig[j] != e) mism++;
    end
    checkOutput({name, "_trace_mismatches"}, mism, 0);
  endtask

  // Main test: vector table first, then multi-cycle corner sequences.
  initial begin
    int doneAt;
    int pulses;
    int repCnt;
    reset_n     = 1'b0;
    bus.I_arm   = 1'b0;
    bus.I_rearm = 1'b0;
    bus.I_match = 1'b0;
    bus.I_abort = 1'b0;
    clearCfg();
    dly[0] = 0;
    wid[0] = 3;
    setConfig(1, 0);

    // Columns: rst_n arm rearm match abort num | {trigger,armed,busy,done,overrun}
    addVec(0, 0, 1, 0, 0, 1, 5'b00000, "reset");
    addVec(1, 1, 1, 0, 0, 1, 5'b01000, "arm_after_release");
    addVec(1, 1, 1, 1, 0, 1, 5'b10100, "pulse_t1");
    addVec(1, 1, 1, 0, 0, 1, 5'b10100, "pulse_t2");
    addVec(1, 1, 1, 0, 0, 1, 5'b10100, "pulse_t3");
    addVec(1, 1, 1, 0, 0, 1, 5'b01010, "done_rearmed");
    addVec(1, 1, 1, 0, 0, 1, 5'b01000, "armed_hold");
    addVec(1, 0, 1, 0, 0, 1, 5'b00000, "disarm");
    addVec(1, 0, 1, 1, 0, 1, 5'b00000, "idle_match_ignored");
    addVec(1, 1, 0, 0, 0, 1, 5'b01000, "arm_again");
    addVec(1, 1, 0, 1, 0, 1, 5'b10100, "pulse2_t1");
    addVec(1, 1, 0, 0, 0, 1, 5'b10100, "pulse2_t2");
    addVec(1, 1, 0, 0, 0, 1, 5'b10100, "pulse2_t3");
    addVec(1, 1, 0, 0, 0, 1, 5'b00010, "done_to_idle");
    addVec(1, 1, 1, 0, 0, 1, 5'b01000, "rearm_from_idle");
    addVec(1, 1, 1, 1, 0, 0, 5'b01010, "zero_pulses_done");
    addVec(1, 1, 1, 0, 0, 0, 5'b01000, "zero_pulses_after");
    addVec(1, 1, 1, 0, 1, 1, 5'b00000, "abort_in_armed");
    addVec(1, 1, 1, 0, 0, 1, 5'b01000, "armed_after_abort");
    addVec(1, 1, 1, 1, 0, 1, 5'b10100, "ovr_pulse_t1");
    addVec(1, 1, 1, 1, 0, 1, 5'b10101, "ovr_flag");
    addVec(1, 1, 1, 0, 0, 1, 5'b10100, "ovr_pulse_t3");
    addVec(1, 1, 1, 0, 0, 1, 5'b01010, "ovr_done");

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i].name, outBits(), int'(vecs[i].exp));
    end

    // Three pulses, delays {5,0,2}, widths {2,0,4}; inputs scrambled mid-run.
    clearCfg();
    dly[0] = 5; dly[1] = 0; dly[2] = 2;
    wid[0] = 2; wid[1] = 0; wid[2] = 4;
    setConfig(3, 0);
    resetAndArm();
    buildExp(3, 0);
    runTrace(20, -1, -1, 3);
    checkTrace("seq3");
    checkOutput("seq3_done_count", countOnes(trDone), 1);
    checkOutput("seq3_done_at", firstOne(trDone), 15);
    checkOutput("seq3_rearmed_at_done", trArmed[15], 1);
    checkOutput("seq3_no_overrun", countOnes(trOvr), 0);

    // Second match while pulse 1 is high: overrun only, timing unchanged.
    setConfig(3, 0);
    resetAndArm();
    runTrace(20, 9, -1, -1);
    checkTrace("ovr3");
    checkOutput("ovr3_overrun_count", countOnes(trOvr), 1);
    checkOutput("ovr3_overrun_at", firstOne(trOvr), 9);
    checkOutput("ovr3_done_at", firstOne(trDone), 15);

    // Abort in the same cycle as a match while pulse 1 is high.
    setConfig(3, 0);
    resetAndArm();
    runTrace(20, 9, 9, -1);
    for (int j = 9; j < expTrig.size(); j++) expTrig[j] = 0;
    checkTrace("abort3");
    checkOutput("abort3_no_done", countOnes(trDone), 0);
    checkOutput("abort3_no_overrun", countOnes(trOvr), 0);
    checkOutput("abort3_idle_busy", trBusy[9], 0);
    checkOutput("abort3_idle_armed", trArmed[9], 0);

    // Reset while O_trigger is high.
    clearCfg();
    dly[0] = 0;
    wid[0] = 10;
    setConfig(1, 0);
    resetAndArm();
    bus.I_match = 1'b1;
    tick();
    bus.I_match = 1'b0;
    tick();
    tick();
    checkOutput("rst_pre_trigger", int'(bus.O_trigger), 1);
    reset_n = 1'b0;
    tick();
    checkOutput("rst_mid_pulse_outputs", outBits(), 0);
    reset_n   = 1'b1;
    bus.I_arm = 1'b1;
    tick();
    checkOutput("rst_release_arm", outBits(), 5'b01000);

    // Pulse count 12 is limited to 8 pulses, and the first width of 0 acts as 1.
    clearCfg();
    for (int k = 0; k < 8; k++) begin
      dly[k] = 1;
      wid[k] = 1;
    end
    wid[0] = 0;
    setConfig(12, 0);
    resetAndArm();
    buildExp(8, 0);
    runTrace(22, -1, -1, -1);
    checkTrace("clamp");
    checkOutput("clamp_pulses", countRising(trTrig), 8);
    checkOutput("clamp_done_at", firstOne(trDone), 16);
    checkOutput("clamp_done_count", countOnes(trDone), 1);

    // Two pulses with I_repeat=2: replayed only when the repeat feature is built in.
`ifdef TRIG_SEQ_REPEAT_EN
    repCnt = 2;
    doneAt = 24;
    pulses = 6;
`else
    repCnt = 0;
    doneAt = 8;
    pulses = 2;
`endif
    clearCfg();
    dly[0] = 3; dly[1] = 2;
    wid[0] = 2; wid[1] = 1;
    setConfig(2, 2);
    resetAndArm();
    buildExp(2, repCnt);
    runTrace(30, -1, -1, -1);
    checkTrace("repeat");
    checkOutput("repeat_pulses", countRising(trTrig), pulses);
    checkOutput("repeat_done_at", firstOne(trDone), doneAt);
    checkOutput("repeat_done_count", countOnes(trDone), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
